mem_access_unit: RTL

//  Load/store bus stage downstream of the controller. Consumes MemWrite, the load strobe and

---
 rtl/mem_access_pkg.sv | 17 +
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/byte_lane_mux.sv | 24 ++
 rtl/mem_access_unit.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store bus stage.
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

  // True when exactly one byte lane is enabled.
  function automatic logic is_byte(input logic [3:0] be);
    return (be != 4'b0000) && ((be & (be - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the load/store stage (master) and memory (slave).
interface mem_access_unit_if #(
  parameter int DATA_W = 32
);
  logic              bus_req;
  logic              bus_we;
  logic [DATA_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/byte_lane_mux.sv
// Byte-lane steering: replicates store bytes across lanes and extracts/zero-extends load bytes.
module byte_lane_mux
  import mem_access_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        be,
  input  logic [1:0]        lane,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [DATA_W-1:0] rdata_ext
);

  always_comb begin
    bus_wdata = wdata;
    rdata_ext = bus_rdata;
    if (is_byte(be)) begin
      bus_wdata = {4{wdata[7:0]}};
      rdata_ext = {{(DATA_W-8){1'b0}}, bus_rdata[{lane, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus stage: one req/ack transaction per access, stalling the core until done,
// with a REQ-cycle timeout that aborts the access and flags bus_err.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_write,
  input  logic              mem_read,
  input  logic [3:0]        be,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              bus_err,
  mem_access_unit_if.master bus
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic [3:0]        be_p0;
  logic              we_p0;
  logic              err_q;
  logic              access;
  logic              capture;
  logic              ack_hit;
  logic              tmo_hit;
  logic [DATA_W-1:0] wdata_lane;
  logic [DATA_W-1:0] rdata_ext;

  assign access = mem_write | mem_read;

  byte_lane_mux #(.DATA_W(DATA_W)) u_lane_mux (
    .be        (be_p0),
    .lane      (addr_p0[1:0]),
    .wdata     (wdata_p0),
    .bus_rdata (bus.bus_rdata),
    .bus_wdata (wdata_lane),
    .rdata_ext (rdata_ext)
  );

  assign bus.bus_we    = we_p0;
  assign bus.bus_addr  = {addr_p0[DATA_W-1:2], 2'b00};
  assign bus.bus_be    = be_p0;
  assign bus.bus_wdata = wdata_lane;

  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    bus.bus_req = 1'b0;
    capture     = 1'b0;
    ack_hit     = 1'b0;
    tmo_hit     = 1'b0;
    rvalid      = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          stall   = 1'b1;
          capture = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        stall       = 1'b1;
        bus.bus_req = 1'b1;
        // An ack in the final counted cycle still wins over the timeout.
        if (bus.bus_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_hit = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        rvalid  = ~we_p0 & ~err_q;
        bus_err = err_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture stage: request fields held stable for the whole bus transaction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_p0  <= '0;
      wdata_p0 <= '0;
      be_p0    <= '0;
      we_p0    <= 1'b0;
      err_q    <= 1'b0;
      rdata    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        addr_p0  <= addr;
        wdata_p0 <= wdata;
        be_p0    <= (be == 4'b0000) ? BE_WORD : be;
        we_p0    <= mem_write;
        cnt_q    <= '0;
        err_q    <= 1'b0;
      end else if (state_q == REQ) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tmo_hit) begin
        err_q <= 1'b1;
        rdata <= '0;
      end else if (ack_hit && !we_p0) begin
        rdata <= rdata_ext;
      end
    end
  end

endmodule
